scie_fir_issuer: RTL and testbench

//  Initiator side of the SCIE custom-instruction interface. Programs the

---
 rtl/scie_fir_issuer.sv | 184 ++++++++++++++++++
 tb/tb_scie_fir_issuer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scie_fir_issuer.sv
// SCIE instruction issuer for a pipelined complex FIR unit: programs taps, streams samples, returns results.
// Optional SCIE_ISSUER_STATS_EN adds free-running sample/result counters.
module scie_fir_issuer #(
   parameter int NTAPS    = 3,
   parameter int DATA_W   = 16,
   parameter int PUSH_GAP = 2,
   parameter int RD_LAT   = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [31:0]       cfg_idx,
   input  logic [DATA_W-1:0] cfg_real,
   input  logic [DATA_W-1:0] cfg_imag,
   output logic              cfg_err,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_real,
   input  logic [DATA_W-1:0] s_imag,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_real,
   output logic [DATA_W-1:0] m_imag,
   output logic              scie_valid,
   output logic [31:0]       scie_insn,
   output logic [DATA_W-1:0] scie_rs1_real,
   output logic [DATA_W-1:0] scie_rs1_imag,
   output logic [31:0]       scie_rs2,
   input  logic [DATA_W-1:0] scie_rd_real,
   input  logic [DATA_W-1:0] scie_rd_imag
`ifdef SCIE_ISSUER_STATS_EN
   ,
   output logic [31:0]       stat_samples,
   output logic [31:0]       stat_results
`endif
);

   localparam logic [31:0] INSN_LOAD = 32'h0000000B;
   localparam logic [31:0] INSN_PUSH = 32'h0000002B;
   localparam logic [31:0] INSN_READ = 32'h0000005B;
   localparam int CNT_MAX = (PUSH_GAP > RD_LAT) ? PUSH_GAP : RD_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PUSH, S_GAP, S_READ, S_WAIT, S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] op_real_q, op_imag_q;
   logic [31:0]       op_idx_q;
   logic [DATA_W-1:0] m_real_q, m_imag_q;
   logic              cfg_err_q;
   logic              cfg_fire, s_fire, cfg_drop, cap_rd;

   assign cfg_fire = cfg_valid & cfg_ready;
   assign s_fire   = s_valid & s_ready;
   assign m_real   = m_real_q;
   assign m_imag   = m_imag_q;
   assign cfg_err  = cfg_err_q;

   always_comb begin
      // NOTE: every output and next-state gets a default first so no latch is inferred.
      state_d       = state_q;
      cnt_d         = cnt_q;
      cfg_ready     = 1'b0;
      s_ready       = 1'b0;
      m_valid       = 1'b0;
      scie_valid    = 1'b0;
      scie_insn     = '0;
      scie_rs1_real = '0;
      scie_rs1_imag = '0;
      scie_rs2      = '0;
      cfg_drop      = 1'b0;
      cap_rd        = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Config wins over samples when both are offered.
            if (cfg_valid) begin
               cfg_ready = 1'b1;
               if (cfg_idx < 32'(NTAPS)) state_d = S_LOAD;
               else                      cfg_drop = 1'b1;
            end else begin
               s_ready = 1'b1;
               if (s_valid) state_d = S_PUSH;
            end
         end
         S_LOAD: begin
            scie_valid    = 1'b1;
            scie_insn     = INSN_LOAD;
            scie_rs1_real = op_real_q;
            scie_rs1_imag = op_imag_q;
            scie_rs2      = op_idx_q;
            state_d       = S_IDLE;
         end
         S_PUSH: begin
            scie_valid    = 1'b1;
            scie_insn     = INSN_PUSH;
            scie_rs1_real = op_real_q;
            scie_rs1_imag = op_imag_q;
            if (PUSH_GAP == 1) begin
               state_d = S_READ;
            end else begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(PUSH_GAP - 1);
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(1)) state_d = S_READ;
            else                    cnt_d   = cnt_q - CNT_W'(1);
         end
         S_READ: begin
            scie_valid = 1'b1;
            scie_insn  = INSN_READ;
            if (RD_LAT == 1) begin
               state_d = S_HOLD;
               cap_rd  = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(RD_LAT - 1);
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_HOLD;
               cap_rd  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            m_valid = 1'b1;
            if (m_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_real_q <= '0;
         op_imag_q <= '0;
         op_idx_q  <= '0;
         m_real_q  <= '0;
         m_imag_q  <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cfg_fire) begin
            op_real_q <= cfg_real;
            op_imag_q <= cfg_imag;
            op_idx_q  <= cfg_idx;
         end else if (s_fire) begin
            op_real_q <= s_real;
            op_imag_q <= s_imag;
            op_idx_q  <= '0;
         end
         if (cfg_drop) cfg_err_q <= 1'b1;
         // rd is passed through bit-exact; scaling belongs to the SCIE unit.
         if (cap_rd) begin
            m_real_q <= scie_rd_real;
            m_imag_q <= scie_rd_imag;
         end
      end
   end

`ifdef SCIE_ISSUER_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_samples <= '0;
         stat_results <= '0;
      end else begin
         if (s_fire)              stat_samples <= stat_samples + 32'd1;
         if (m_valid && m_ready)  stat_results <= stat_results + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_scie_fir_issuer.sv
// Scoreboard bench for scie_fir_issuer with a behavioural 3-tap complex FIR SCIE unit.
module tb_scie_fir_issuer;
   localparam logic [31:0] LOAD = 32'h0000000B;
   localparam logic [31:0] PUSH = 32'h0000002B;
   localparam logic [31:0] READ = 32'h0000005B;

   logic        clock = 1'b0, reset_n = 1'b0;
   logic        cfg_valid = 1'b0, cfg_ready, cfg_err;
   logic [31:0] cfg_idx = '0;
   logic [15:0] cfg_real = '0, cfg_imag = '0;
   logic        s_valid = 1'b0, s_ready;
   logic [15:0] s_real = '0, s_imag = '0;
   logic        m_valid, m_ready = 1'b1;
   logic [15:0] m_real, m_imag;
   logic        scie_valid;
   logic [31:0] scie_insn, scie_rs2;
   logic [15:0] scie_rs1_real, scie_rs1_imag;
   logic [15:0] scie_rd_real = 16'h5A5A, scie_rd_imag = 16'h5A5A;
`ifdef SCIE_ISSUER_STATS_EN
   logic [31:0] stat_samples, stat_results;
`endif

   scie_fir_issuer dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_real(cfg_real), .cfg_imag(cfg_imag), .cfg_err(cfg_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
      .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
      .scie_valid(scie_valid), .scie_insn(scie_insn),
      .scie_rs1_real(scie_rs1_real), .scie_rs1_imag(scie_rs1_imag),
      .scie_rs2(scie_rs2), .scie_rd_real(scie_rd_real), .scie_rd_imag(scie_rd_imag)
`ifdef SCIE_ISSUER_STATS_EN
      , .stat_samples(stat_samples), .stat_results(stat_results)
`endif
   );

   always #5 clock = ~clock;

   int n_vec = 0, n_bad = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } res_t;
   res_t exp_q[$];

   // Scoreboard monitor: pops on every result handshake.
   always @(negedge clock) begin
      res_t e;
      if (reset_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("m_real", $signed(m_real), e.re);
            check("m_imag", $signed(m_imag), e.im);
         end
      end
   end

   // Behavioural SCIE unit: rd is valid for one cycle starting mid-READ.
   logic signed [15:0] tap_re[3], tap_im[3], h_re[3], h_im[3];
   int acc_re = 0, acc_im = 0, loads = 0, cyc = 0, push_cyc = 0, opviol = 0;
   initial for (int k = 0; k < 3; k++) begin
      tap_re[k] = '0; tap_im[k] = '0; h_re[k] = '0; h_im[k] = '0;
   end

   always @(negedge clock) begin
      cyc++;
      scie_rd_real = 16'h5A5A;
      scie_rd_imag = 16'h5A5A;
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin h_re[k] = '0; h_im[k] = '0; end
      end
      if (scie_valid) begin
         case (scie_insn)
            LOAD: begin
               loads++;
               if (scie_rs2 < 32'd3) begin
                  tap_re[scie_rs2[1:0]] = scie_rs1_real;
                  tap_im[scie_rs2[1:0]] = scie_rs1_imag;
               end else opviol++;
            end
            PUSH: begin
               if (scie_rs2 != 0) opviol++;
               h_re[2] = h_re[1]; h_im[2] = h_im[1];
               h_re[1] = h_re[0]; h_im[1] = h_im[0];
               h_re[0] = scie_rs1_real; h_im[0] = scie_rs1_imag;
               acc_re = 0; acc_im = 0;
               for (int k = 0; k < 3; k++) begin
                  acc_re += tap_re[k] * h_re[k] - tap_im[k] * h_im[k];
                  acc_im += tap_re[k] * h_im[k] + tap_im[k] * h_re[k];
               end
               push_cyc = cyc;
            end
            READ: begin
               if (scie_rs1_real != 0 || scie_rs1_imag != 0 || scie_rs2 != 0) opviol++;
               check("push_to_read_gap", cyc - push_cyc, 2);
               scie_rd_real = 16'(acc_re);
               scie_rd_imag = 16'(acc_im);
            end
            default: opviol++;
         endcase
      end else if (scie_insn != 0 || scie_rs1_real != 0 || scie_rs1_imag != 0 || scie_rs2 != 0) begin
         opviol++;
      end
   end

   task automatic send_cfg(input logic [31:0] idx, input logic [15:0] re, input logic [15:0] im);
      bit ok = 0;
      @(posedge clock); #1;
      cfg_valid = 1'b1; cfg_idx = idx; cfg_real = re; cfg_imag = im;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (cfg_ready) ok = 1;
      end
      if (!ok) check("cfg_ready_timeout", 0, 1);
      @(posedge clock); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic load_tap(input logic [31:0] idx, input logic [15:0] re, input logic [15:0] im);
      send_cfg(idx, re, im);
      @(negedge clock);
      check("load_valid", scie_valid, 1);
      check("load_insn", scie_insn, LOAD);
      check("load_rs2", scie_rs2, idx);
      check("load_rs1_real", $signed(scie_rs1_real), $signed(re));
      @(negedge clock);
      check("load_one_beat", scie_valid, 0);
   endtask

   task automatic send_sample(input logic [15:0] re, input logic [15:0] im);
      bit ok = 0;
      @(posedge clock); #1;
      s_valid = 1'b1; s_real = re; s_imag = im;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (s_ready) ok = 1;
      end
      if (!ok) check("s_ready_timeout", 0, 1);
      @(posedge clock); #1;
      s_valid = 1'b0;
   endtask

   task automatic push_exp(input logic signed [15:0] re, input logic signed [15:0] im);
      res_t e;
      e.re = re; e.im = im;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0) ok = 1;
      end
      if (!ok) check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int l0;
      logic [15:0] hr, hi;
      bit ok;
      // Reset state
      #2;
      check("rst_scie_valid", scie_valid, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_cfg_ready", cfg_ready, 0);
      check("rst_m_real", m_real, 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Taps, then first sample with zero history
      load_tap(32'd0, -16'sd34, -16'sd15);
      load_tap(32'd1, 16'sd24, 16'sd37);
      load_tap(32'd2, 16'sd13, -16'sd4);
      push_exp(16'sd1249, 16'sd1404);
      send_sample(-16'sd46, -16'sd21);
      @(negedge clock);
      check("push_insn", scie_insn, PUSH);
      check("push_rs1_imag", $signed(scie_rs1_imag), -21);
      wait_drain();

      // Backpressure on the result stream
      push_exp(-16'sd361, -16'sd2221);
      m_ready = 1'b0;
      send_sample(16'sd1, 16'sd0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (m_valid) ok = 1;
      end
      check("hold_reached", ok, 1);
      hr = m_real; hi = m_imag;
      for (int i = 0; i < 5; i++) begin
         check("hold_m_valid", m_valid, 1);
         check("hold_m_stable", {m_real, m_imag}, {hr, hi});
         check("hold_s_ready", s_ready, 0);
         check("hold_scie_valid", scie_valid, 0);
         @(negedge clock);
      end
      @(posedge clock); #1 m_ready = 1'b1;
      wait_drain();

      // Out-of-range tap index
      l0 = loads;
      send_cfg(32'd3, 16'sd99, 16'sd99);
      repeat (4) @(negedge clock);
      check("bad_idx_no_issue", loads, l0);
      check("bad_idx_cfg_err", cfg_err, 1);

      // Config and sample offered together
      push_exp(-16'sd643, -16'sd86);
      @(posedge clock); #1;
      cfg_valid = 1'b1; cfg_idx = 32'd2; cfg_real = 16'sd13; cfg_imag = -16'sd4;
      s_valid = 1'b1; s_real = 16'sd0; s_imag = 16'sd1;
      @(negedge clock);
      check("prio_cfg_ready", cfg_ready, 1);
      check("prio_s_ready", s_ready, 0);
      @(posedge clock); #1 cfg_valid = 1'b0;
      @(negedge clock);
      check("prio_load_first", scie_insn, LOAD);
      @(negedge clock);
      check("prio_s_ready_next", s_ready, 1);
      @(posedge clock); #1 s_valid = 1'b0;
      @(negedge clock);
      check("prio_push_next", scie_insn, PUSH);
      wait_drain();
      check("cfg_err_sticky", cfg_err, 1);

      // Reset while in GAP
      send_sample(16'sd5, 16'sd5);
      @(posedge clock); #2;
      check("gap_s_ready", s_ready, 0);
      reset_n = 1'b0;
      #1;
      check("async_rst_scie_valid", scie_valid, 0);
      check("async_rst_m_valid", m_valid, 0);
      check("async_rst_idle", s_ready, 1);
      repeat (3) @(negedge clock);
      @(posedge clock); #1 reset_n = 1'b1;
      check("post_rst_cfg_err", cfg_err, 0);
      push_exp(-16'sd68, -16'sd30);
      send_sample(16'sd2, 16'sd0);
      wait_drain();

      repeat (3) @(negedge clock);
      check("operands_zero_when_idle", opviol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
